// File: rtl/fifo_wc_if.sv
// fifo_wc_if: producer/consumer bundle for the width-converting FIFO.
// Ports: en_w/data_in (write side), en_r/data_out/rd_valid (read side),
//        occupancy flags, level and sticky error flags (status side).
interface fifo_wc_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int DEPTH = 8
);
  localparam int LVL_W = $clog2(DEPTH * (IN_W / OUT_W)) + 1;

  logic             en_w;
  logic [IN_W-1:0]  data_in;
  logic             en_r;
  logic [OUT_W-1:0] data_out;
  logic             rd_valid;
  logic             full_flag;
  logic             empty_flag;
  logic             almost_full;
  logic             almost_empty;
  logic [LVL_W-1:0] level;
  logic             err_ovf;
  logic             err_udf;

  // master: the user of the FIFO (drives requests, observes status)
  modport master (
    output en_w, data_in, en_r,
    input  data_out, rd_valid, full_flag, empty_flag, almost_full,
           almost_empty, level, err_ovf, err_udf
  );

  // slave: the FIFO itself
  modport slave (
    input  en_w, data_in, en_r,
    output data_out, rd_valid, full_flag, empty_flag, almost_full,
           almost_empty, level, err_ovf, err_udf
  );
endinterface

// File: rtl/fifo_wc.sv
// fifo_wc: single-clock FIFO, IN_W-bit words in, OUT_W-bit slices out (LSB slice first).
// Latency: a written word is readable next cycle; read data appears one cycle after en_r (zero with FIFO_FWFT_EN).
// Backpressure: writes while full / reads while empty are dropped and set sticky err_ovf / err_udf.
// Optional macro FIFO_FWFT_EN: first-word-fall-through read mode (data_out shows the head slice combinationally).
// Ports: clk; rst (async active-low); bus (fifo_wc_if.slave): en_w/data_in, en_r/data_out/rd_valid,
//        full_flag, empty_flag, almost_full, almost_empty, level, err_ovf, err_udf.
module fifo_wc #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1
) (
  input logic      clk,
  input logic      rst,
  fifo_wc_if.slave bus
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUB_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int ENT_W = $clog2(DEPTH) + 1;
  localparam int LVL_W = $clog2(DEPTH * RATIO) + 1;

  logic [IN_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [SUB_W-1:0] sub_idx;
  logic [ENT_W-1:0] entries;   // whole or partially read words held
  logic             ovf_q;
  logic             udf_q;

  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;
  logic             last_slice;
  logic             pop_word;
  logic [IN_W-1:0]  head_word;
  logic [OUT_W-1:0] head;

  // Everything below is decoded from registered state, so flags move on
  // the same edge as occupancy.
  assign level      = LVL_W'(entries) * LVL_W'(RATIO) - LVL_W'(sub_idx);
  assign full       = (entries == ENT_W'(DEPTH));
  assign empty      = (level == '0);
  assign wr_acc     = bus.en_w && !full;
  assign rd_acc     = bus.en_r && !empty;
  assign last_slice = (sub_idx == SUB_W'(RATIO - 1));
  assign pop_word   = rd_acc && last_slice;

  // Not full implies wr_ptr != rd_ptr whenever the FIFO holds data, so the
  // head word is never the one being written this cycle (no bypass).
  assign head_word  = mem[rd_ptr];
  assign head       = head_word[OUT_W * int'(sub_idx) +: OUT_W];

  // Storage carries no reset; contents are irrelevant until written.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      sub_idx <= '0;
      entries <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_word) rd_ptr <= rd_ptr + 1'b1;
      if (rd_acc)   sub_idx <= last_slice ? '0 : sub_idx + 1'b1;
      case ({wr_acc, pop_word})
        2'b10:   entries <= entries + 1'b1;
        2'b01:   entries <= entries - 1'b1;
        default: entries <= entries;
      endcase
      // full/empty are pre-edge values: a same-cycle read does not rescue a write
      if (bus.en_w && full)  ovf_q <= 1'b1;
      if (bus.en_r && empty) udf_q <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out = empty ? '0 : head;
  assign bus.rd_valid = !empty;
`else
  logic [OUT_W-1:0] dout_q;
  logic             vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= rd_acc;
      if (rd_acc) dout_q <= head;
    end
  end

  assign bus.data_out = dout_q;
  assign bus.rd_valid = vld_q;
`endif

  assign bus.full_flag    = full;
  assign bus.empty_flag   = empty;
  assign bus.almost_full  = (entries >= ENT_W'(DEPTH - AF_MARGIN));
  assign bus.almost_empty = (level <= LVL_W'(AE_MARGIN));
  assign bus.level        = level;
  assign bus.err_ovf      = ovf_q;
  assign bus.err_udf      = udf_q;
endmodule

// File: tb/tb_fifo_wc.sv
// tb_fifo_wc: bench for fifo_wc in registered read mode (32-bit in, 8-bit out, 8 entries).
// Table rows carry inputs plus expected flags; read data goes through a scoreboard queue.
// Hand-written sequences cover wrap-around, simultaneous read/write and asynchronous reset.
module tb_fifo_wc;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  fifo_wc_if #(.IN_W(32), .OUT_W(8), .DEPTH(8)) bus ();

  fifo_wc #(
    .IN_W(32), .OUT_W(8), .DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] d;
    logic        r;
    int          lvl;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] m_q[$];     // bytes the FIFO should hold, oldest first
  logic [7:0] rd_exp[$];  // bytes expected on data_out after the next edge

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one clock of stimulus; model acceptance from pre-edge state.
  task automatic cycle(input logic w, input logic [31:0] d, input logic r);
    logic       m_full;
    logic       m_empty;
    logic       exp_v;
    logic [7:0] e;
    m_full  = ((m_q.size() + 3) / 4) == 8;
    m_empty = (m_q.size() == 0);
    bus.en_w    = w;
    bus.data_in = d;
    bus.en_r    = r;
    exp_v = 1'b0;
    if (r && !m_empty) begin
      rd_exp.push_back(m_q.pop_front());
      exp_v = 1'b1;
    end
    if (w && !m_full)
      for (int k = 0; k < 4; k++) m_q.push_back(d[8*k +: 8]);
    @(posedge clk);
    #1;
    bus.en_w = 1'b0;
    bus.en_r = 1'b0;
    chk("rd_valid", 32'(bus.rd_valid), 32'(exp_v));
    if (exp_v) begin
      e = rd_exp.pop_front();
      chk("data_out", 32'(bus.data_out), 32'(e));
    end
    chk("level_vs_model", 32'(bus.level), 32'(m_q.size()));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"},    32'(bus.level),        32'd0);
    chk({tag, "_empty"},    32'(bus.empty_flag),   32'd1);
    chk({tag, "_full"},     32'(bus.full_flag),    32'd0);
    chk({tag, "_ae"},       32'(bus.almost_empty), 32'd1);
    chk({tag, "_af"},       32'(bus.almost_full),  32'd0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid),     32'd0);
    chk({tag, "_data_out"}, 32'(bus.data_out),     32'd0);
    chk({tag, "_ovf"},      32'(bus.err_ovf),      32'd0);
    chk({tag, "_udf"},      32'(bus.err_udf),      32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_q.delete();
    rd_exp.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        v;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [7:0]  bytes_exp[4];
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.en_w = 1'b0;
    bus.en_r = 1'b0;
    bus.data_in = '0;

    // 1: asynchronous reset asserted mid-cycle, visible before any edge
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_reset_state("rst_async");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // 2/3: fill to full plus one dropped write, then drain plus one extra read
    for (int i = 0; i < 9; i++) begin
      v.w = 1'b1; v.d = 32'h03020100 + 32'(i) * 32'h04040404; v.r = 1'b0;
      v.lvl = (i < 8) ? 4 * (i + 1) : 32;
      v.full = (i >= 7); v.empty = 1'b0; v.af = (i >= 6); v.ae = 1'b0;
      v.ovf = (i == 8); v.udf = 1'b0;
      tbl.push_back(v);
    end
    for (int j = 0; j < 33; j++) begin
      v.w = 1'b0; v.d = '0; v.r = 1'b1;
      v.lvl = (j < 32) ? 31 - j : 0;
      v.full = (v.lvl > 28); v.af = (v.lvl > 24);
      v.empty = (v.lvl == 0); v.ae = (v.lvl <= 1);
      v.ovf = 1'b1; v.udf = (j == 32);
      tbl.push_back(v);
    end
    foreach (tbl[n]) begin
      cycle(tbl[n].w, tbl[n].d, tbl[n].r);
      chk("tbl_level", 32'(bus.level),        32'(tbl[n].lvl));
      chk("tbl_full",  32'(bus.full_flag),    32'(tbl[n].full));
      chk("tbl_empty", 32'(bus.empty_flag),   32'(tbl[n].empty));
      chk("tbl_af",    32'(bus.almost_full),  32'(tbl[n].af));
      chk("tbl_ae",    32'(bus.almost_empty), 32'(tbl[n].ae));
      chk("tbl_ovf",   32'(bus.err_ovf),      32'(tbl[n].ovf));
      chk("tbl_udf",   32'(bus.err_udf),      32'(tbl[n].udf));
    end
    chk("udf_data_held", 32'(bus.data_out), 32'h1F);

    // 4: wrap-around with random data; errors cleared by reset first
    do_reset();
    chk("rst_sync_ovf", 32'(bus.err_ovf), 32'd0);
    chk("rst_sync_udf", 32'(bus.err_udf), 32'd0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, 1'b0);
      chk("wrap_level_6w", 32'(bus.level), 32'd24);
      for (int i = 0; i < 24; i++) cycle(1'b0, '0, 1'b1);
      chk("wrap_empty", 32'(bus.empty_flag), 32'd1);
    end
    chk("wrap_no_errors", 32'({bus.err_ovf, bus.err_udf}), 32'd0);

    // 5: simultaneous read and write at one word
    w1 = $urandom;
    w2 = $urandom;
    cycle(1'b1, w1, 1'b0);
    chk("rw_level_pre", 32'(bus.level), 32'd4);
    cycle(1'b1, w2, 1'b1);
    chk("rw_level", 32'(bus.level), 32'd7);
    chk("rw_byte0", 32'(bus.data_out), 32'(w1[7:0]));
    cycle(1'b0, '0, 1'b1);
    chk("rw_byte1", 32'(bus.data_out), 32'(w1[15:8]));

    // 6: asynchronous reset with data held, then a clean word afterwards
    cycle(1'b1, $urandom, 1'b0);
    chk("pre_rst_level", 32'(bus.level), 32'd10);
    #2 rst = 1'b0;
    #1 chk_reset_state("rst_mid");
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    m_q.delete();
    rd_exp.delete();
    bytes_exp[0] = 8'hAA; bytes_exp[1] = 8'hBB;
    bytes_exp[2] = 8'hCC; bytes_exp[3] = 8'hDD;
    cycle(1'b1, 32'hDDCCBBAA, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("post_rst_byte", 32'(bus.data_out), 32'(bytes_exp[i]));
    end
    chk("post_rst_empty", 32'(bus.empty_flag), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wc.md
Name: fifo_wc

Overview:
- Parametrised successor to the team's 32-in/8-out FIFO: synchronous single-clock FIFO with write/read width conversion (wide write words, narrow read slices).
- Adds level count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a compile-time first-word-fall-through read mode.
- Sits between a wide producer (bus/register block) and a narrow serial or byte consumer.

Parameters:
- IN_W, 32, write word width; must be an integer multiple of OUT_W.
- OUT_W, 8, read slice width.
- DEPTH, 8, storage entries in IN_W words; power of 2, at least 2.
- AF_MARGIN, 1, almost_full asserts when entries >= DEPTH-AF_MARGIN.
- AE_MARGIN, 1, almost_empty asserts when level <= AE_MARGIN.
- Derived localparams: RATIO = IN_W/OUT_W; LVL_W = $clog2(DEPTH*RATIO)+1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset. Asserting low clears all state immediately; release is synchronous to clk.
- en_w  in  1  write request.
- data_in  in  IN_W  write word.
- en_r  in  1  read request (pop one OUT_W slice).
- data_out  out  OUT_W  read slice.
- rd_valid  out  1  data_out holds valid data (see Behaviour).
- full_flag  out  1  entries == DEPTH.
- empty_flag  out  1  level == 0.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- level  out  LVL_W  unread OUT_W slices = entries*RATIO - sub_idx.
- err_ovf  out  1  sticky: write attempted while full.
- err_udf  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst=0): pointers, sub_idx, and level go to 0. empty_flag=1, almost_empty=1. full_flag, almost_full, data_out, rd_valid, err_ovf, and err_udf go to 0. Memory contents are don't-care.
- Storage: DEPTH x IN_W array, with wr_ptr, rd_ptr (log2 DEPTH bits each, wrap DEPTH-1 -> 0) and sub_idx (0..RATIO-1).
- Write is accepted on an edge when en_w=1 and full_flag=0. The array stores data_in at wr_ptr, and wr_ptr increments.
- Write with full_flag=1 is dropped and sets err_ovf. This holds even if the same-cycle read frees an entry: full is evaluated from pre-edge state.
- Read is accepted when en_r=1 and empty_flag=0. The head slice is mem[rd_ptr][sub_idx*OUT_W +: OUT_W] (slice 0 = LSBs, sent first).
  - sub_idx increments on each accepted read.
  - On sub_idx==RATIO-1, sub_idx goes to 0 and rd_ptr increments, which frees the entry.
- Read with empty_flag=1 is ignored and sets err_udf. A word written in cycle N becomes readable from cycle N+1 (no write-to-read bypass).
- Simultaneous accepted read and write: both take effect. level' = level + RATIO - 1.
- All flags and level are registered or derived from registered state. They update on the edge that changes occupancy, with no extra latency.
- Default (registered) read mode:
  - On an accepted read edge, data_out <= head slice and rd_valid <= 1. Data is therefore visible in the cycle after en_r.
  - With no accepted read, rd_valid <= 0 and data_out holds its value.
- Error flags clear only on reset.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - data_out is combinationally the current head slice.
  - rd_valid = ~empty_flag.
  - en_r acknowledges/pops the displayed slice, with zero read latency.
  - data_out is 0 when empty.
- Undefined: registered read mode as described in Behaviour (1-cycle latency, rd_valid pulse).
- Flags, level, and errors are identical in both modes.

Test Plan:
1. Hold rst=0 for 3 cycles mid-clock -> all outputs reach reset values immediately (asynchronous): empty_flag=1, level=0, rd_valid=0, err_ovf=err_udf=0.
2. Write i=0..7 with data_in=32'h03020100+i*32'h04040404 -> almost_full=1 after the 7th write, full_flag=1 and level=32 after the 8th; a 9th write is dropped and sets err_ovf=1.
3. Then perform 32 consecutive reads -> data_out sequence is 8'h00,8'h01,...,8'h1F (registered mode: each slice one cycle after its en_r). Expected flags: almost_empty=1 at level<=1, empty_flag=1 after the 32nd read, and a 33rd read sets err_udf=1 with data_out held.
4. Wrap-around: write 6, read 24, write 6, read 24 -> pointers wrap past DEPTH-1 and output data is in order with no loss.
5. At level=4 (one word), assert en_w and en_r together for one cycle -> level=7 and the next slice read is byte 1 of the first word.
6. With level=10, drive rst low asynchronously -> immediate clear. After release, write 32'hDDCCBBAA and read 4 slices -> AA, BB, CC, DD.
